// File: rtl/axis_arb_pkg.sv
// Shared types for the round-robin AXI-stream arbiter: FSM states, index width
// helper and the double-width rotating-priority mask.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int MAX_M = 16;

  // Holds {req, req & above_ptr} so a single lowest-set-bit search wraps around.
  typedef logic [2*MAX_M-1:0] rr_mask_t;

  function automatic int idw(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_pick.sv
// Combinational rotating-priority picker: first request after ptr wins,
// wrapping modulo M.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter  int M   = 4,
  localparam int IDW = idw(M)
) (
  input  logic [M-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] winner,
  output logic           any_req
);

  rr_mask_t dbl;
  rr_mask_t lowest;

  always_comb begin
    dbl = '0;
    for (int j = 0; j < M; j++) begin
      dbl[j]     = req[j] && (j > int'(ptr));
      dbl[j + M] = req[j];
    end
    lowest = dbl & (~dbl + rr_mask_t'(1));
    winner = '0;
    // lowest is one-hot; the upper copy maps back onto the same requester
    for (int i = 0; i < 2*MAX_M; i++) begin
      if (lowest[i]) winner = IDW'(i % M);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one AXI-stream among M requesters,
// with a single registered output stage.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int n   = 4,
  parameter  int M   = 4,
  localparam int NB  = n * 8,
  localparam int IDW = idw(M)
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [M-1:0]    cfg_enable,
  input  logic [M*NB-1:0] in_tdata,
  input  logic [M-1:0]    in_tvalid,
  input  logic [M-1:0]    in_tlast,
  output logic [M-1:0]    in_tready,
  output logic [NB-1:0]   out_tdata,
  output logic            out_tvalid,
  output logic            out_tlast,
  output logic [IDW-1:0]  out_tid,
  input  logic            out_tready,
  output logic            busy
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [M-1:0]   req;
  logic [IDW-1:0] winner;
  logic           any_req;
  logic           stage_ready;
  logic           accept;

  logic [NB-1:0]  data_p1;
  logic           last_p1;
  logic [IDW-1:0] tid_p1;
  logic           vld_p1;

  assign req = in_tvalid & cfg_enable;

  rr_pick #(.M(M)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= IDW'(M - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    in_tready   = '0;
    accept      = 1'b0;
    stage_ready = !vld_p1 || out_tready;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Enable mask is ignored here so a granted packet is never truncated
        in_tready[grant_q] = stage_ready;
        accept             = stage_ready && in_tvalid[grant_q];
        if (accept && in_tlast[grant_q]) begin
          state_d = IDLE;
          ptr_d   = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage (p1): loads on input handshake, drains on output handshake
  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      tid_p1  <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= in_tdata[grant_q*NB +: NB];
      last_p1 <= in_tlast[grant_q];
      tid_p1  <= grant_q;
    end else if (out_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_tdata  = data_p1;
  assign out_tvalid = vld_p1;
  assign out_tlast  = last_p1;
  assign out_tid    = tid_p1;
  assign busy       = (state_q == BUSY);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scenario bench for axis_rr_arbiter: per-requester source queues, captured
// output beats compared against expected beats queued with the stimulus.
`timescale 1ns/1ps
module tb_axis_rr_arbiter;

  localparam int N   = 4;
  localparam int M   = 4;
  localparam int NB  = 32;
  localparam int IDW = 2;

  logic            aclk = 1'b0;
  logic            areset;
  logic [M-1:0]    cfg_enable;
  logic [M*NB-1:0] in_tdata;
  logic [M-1:0]    in_tvalid;
  logic [M-1:0]    in_tlast;
  logic [M-1:0]    in_tready;
  logic [NB-1:0]   out_tdata;
  logic            out_tvalid;
  logic            out_tlast;
  logic [IDW-1:0]  out_tid;
  logic            out_tready;
  logic            busy;

  axis_rr_arbiter #(.n(N), .M(M)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .cfg_enable (cfg_enable),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tlast   (in_tlast),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tlast  (out_tlast),
    .out_tid    (out_tid),
    .out_tready (out_tready),
    .busy       (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [IDW-1:0] tid;
    logic           last;
    logic [NB-1:0]  data;
  } beat_t;

  typedef struct packed {
    logic          last;
    logic [NB-1:0] data;
  } src_t;

  src_t  src_q[M][$];
  beat_t obs_q[$];
  beat_t exp_q[$];
  beat_t eq[M][$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ready_mode;
  int gap_mode;
  int gap[M];
  int stall_err;
  int ready_err;
  logic [M-1:0] allowed_rdy;
  logic [M-1:0] hs_in;
  logic  prev_stall;
  beat_t prev_beat;

  task automatic add_beat(input int i, input logic [NB-1:0] d, input logic l, input bit to_exp);
    src_t s;
    beat_t b;
    s.last = l;
    s.data = d;
    src_q[i].push_back(s);
    b.tid  = IDW'(i);
    b.last = l;
    b.data = d;
    if (to_exp) exp_q.push_back(b);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < M; i++) begin
      if (hs_in[i]) begin
        if (src_q[i][0].last || gap_mode == 0) gap[i] = 0;
        else gap[i] = $urandom_range(0, 3);
        void'(src_q[i].pop_front());
        in_tvalid[i] = 1'b0;
      end
      if (!in_tvalid[i] && src_q[i].size() > 0) begin
        if (gap[i] > 0) gap[i]--;
        else begin
          in_tvalid[i]          = 1'b1;
          in_tdata[i*NB +: NB]  = src_q[i][0].data;
          in_tlast[i]           = src_q[i][0].last;
        end
      end
    end
    case (ready_mode)
      0:       out_tready = 1'b1;
      1:       out_tready = (cyc % 5) >= 3;
      default: out_tready = ($urandom_range(0, 3) != 0);
    endcase
    hs_in = '0;
  endtask

  task automatic step();
    beat_t cur;
    @(negedge aclk);
    cur.tid  = out_tid;
    cur.last = out_tlast;
    cur.data = out_tdata;
    if (prev_stall && out_tvalid && cur !== prev_beat) stall_err++;
    if ((in_tready & ~allowed_rdy) != '0) ready_err++;
    if (out_tvalid && !out_tready && in_tready != '0) ready_err++;
    prev_stall = out_tvalid && !out_tready;
    prev_beat  = cur;
    hs_in      = in_tvalid & in_tready;
    if (out_tvalid && out_tready) obs_q.push_back(cur);
    @(posedge aclk);
    #1;
    cyc++;
    drive_inputs();
  endtask

  task automatic run(input int want, input int budget, output bit timeout);
    int k = 0;
    while (obs_q.size() < want && k < budget) begin
      step();
      k++;
    end
    timeout = (obs_q.size() < want);
  endtask

  task automatic do_reset();
    areset      = 1'b1;
    in_tvalid   = '0;
    in_tlast    = '0;
    in_tdata    = '0;
    cfg_enable  = '1;
    out_tready  = 1'b1;
    ready_mode  = 0;
    gap_mode    = 0;
    allowed_rdy = '1;
    for (int i = 0; i < M; i++) begin
      src_q[i].delete();
      eq[i].delete();
      gap[i] = 0;
    end
    repeat (2) @(posedge aclk);
    #1;
    areset     = 1'b0;
    obs_q.delete();
    exp_q.delete();
    prev_stall = 1'b0;
    hs_in      = '0;
    stall_err  = 0;
    ready_err  = 0;
  endtask

  task automatic test_reset();
    bit to;
    do_reset();
    total++;
    if ({out_tvalid, out_tlast, busy} !== 3'b000 || out_tdata !== '0 || out_tid !== '0 || in_tready !== '0) begin
      bad++;
      $display("FAIL reset_state: got vld=%b last=%b busy=%b data=%h tid=%0d rdy=%b want all zero",
               out_tvalid, out_tlast, busy, out_tdata, out_tid, in_tready);
    end
    // req1 completes a packet so the pointer moves away from its reset value
    add_beat(1, "pre!", 1'b1, 1'b0);
    drive_inputs();
    run(1, 50, to);
    repeat (2) step();
    obs_q.delete();
    add_beat(0, "0123", 1'b0, 1'b0);
    add_beat(0, "4567", 1'b0, 1'b0);
    drive_inputs();
    run(2, 50, to);
    total++;
    if (to || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_midpkt_wait: got timeout=%b busy=%b want timeout=0 busy=1", to, busy);
    end
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset     = 1'b0;
    prev_stall = 1'b0;
    total++;
    if ({out_tvalid, out_tlast, busy} !== 3'b000 || out_tdata !== '0 || out_tid !== '0 || in_tready !== '0) begin
      bad++;
      $display("FAIL reset_pulse: got vld=%b last=%b busy=%b data=%h tid=%0d rdy=%b want all zero",
               out_tvalid, out_tlast, busy, out_tdata, out_tid, in_tready);
    end
    obs_q.delete();
    // With ptr back at M-1, requester 1 outranks requester 2
    add_beat(1, "ABCD", 1'b1, 1'b1);
    add_beat(2, "WXYZ", 1'b1, 1'b1);
    drive_inputs();
    run(2, 50, to);
    total++;
    if (to || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      bad++;
      $display("FAIL reset_after: got timeout=%b b0=%h b1=%h want %h %h",
               to, obs_q.size() > 0 ? obs_q[0] : '0, obs_q.size() > 1 ? obs_q[1] : '0, exp_q[0], exp_q[1]);
    end
  endtask

  task automatic test_single();
    do_reset();
    add_beat(0, "0123", 1'b0, 1'b0);
    add_beat(0, "4567", 1'b0, 1'b0);
    add_beat(0, "89ab", 1'b1, 1'b0);
    drive_inputs();
    step();
    total++;
    if (out_tvalid !== 1'b0 || busy !== 1'b1 || in_tready !== 4'b0001) begin
      bad++;
      $display("FAIL single_grant: got vld=%b busy=%b rdy=%b want 0 1 0001", out_tvalid, busy, in_tready);
    end
    step();
    total++;
    if ({out_tvalid, out_tlast} !== 2'b10 || out_tdata !== "0123" || out_tid !== 2'd0) begin
      bad++;
      $display("FAIL single_beat0: got vld=%b last=%b data=%h tid=%0d want 1 0 %h 0",
               out_tvalid, out_tlast, out_tdata, out_tid, 32'("0123"));
    end
    step();
    total++;
    if ({out_tvalid, out_tlast} !== 2'b10 || out_tdata !== "4567" || out_tid !== 2'd0) begin
      bad++;
      $display("FAIL single_beat1: got vld=%b last=%b data=%h tid=%0d want 1 0 %h 0",
               out_tvalid, out_tlast, out_tdata, out_tid, 32'("4567"));
    end
    step();
    total++;
    if ({out_tvalid, out_tlast, busy} !== 3'b110 || out_tdata !== "89ab" || out_tid !== 2'd0) begin
      bad++;
      $display("FAIL single_beat2: got vld=%b last=%b busy=%b data=%h want 1 1 0 %h",
               out_tvalid, out_tlast, busy, out_tdata, 32'("89ab"));
    end
    step();
    total++;
    if (out_tvalid !== 1'b0 || obs_q.size() != 3) begin
      bad++;
      $display("FAIL single_drain: got vld=%b beats=%0d want 0 3", out_tvalid, obs_q.size());
    end
  endtask

  task automatic test_round_robin();
    bit to;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < M; i++)
        for (int b = 0; b < 2; b++)
          add_beat(i, {8'(i), 8'(r), 8'(b), 8'hA5}, b == 1, 1'b1);
    drive_inputs();
    run(16, 200, to);
    total++;
    if (to) begin
      bad++;
      $display("FAIL rr_timeout: got %0d beats want 16", obs_q.size());
    end
    for (int k = 0; k < 16 && k < obs_q.size(); k++) begin
      total++;
      if (obs_q[k] !== exp_q[k]) begin
        bad++;
        $display("FAIL rr_beat%0d: got tid=%0d data=%h want tid=%0d data=%h",
                 k, obs_q[k].tid, obs_q[k].data, exp_q[k].tid, exp_q[k].data);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int mism = 0;
    do_reset();
    ready_mode  = 1;
    allowed_rdy = 4'b0100;
    for (int b = 0; b < 5; b++) add_beat(2, {8'h22, 16'(b * 3 + 1), 8'h5A}, b == 4, 1'b1);
    drive_inputs();
    run(5, 200, to);
    repeat (10) step();
    total++;
    if (to || obs_q.size() != 5) begin
      bad++;
      $display("FAIL bp_count: got %0d handshakes want 5", obs_q.size());
    end
    for (int k = 0; k < 5 && k < obs_q.size(); k++) if (obs_q[k] !== exp_q[k]) mism++;
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL bp_data: got %0d mismatched beats want 0", mism);
    end
    total++;
    if (stall_err != 0 || ready_err != 0) begin
      bad++;
      $display("FAIL bp_stable: got stall_err=%0d ready_err=%0d want 0 0", stall_err, ready_err);
    end
  endtask

  task automatic test_mask();
    bit to;
    int mism = 0;
    do_reset();
    cfg_enable = 4'b1010;
    for (int b = 0; b < 4; b++) add_beat(1, {8'h11, 8'hAA, 16'(b)}, b == 3, 1'b1);
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < 2; b++) add_beat(3, {8'h33, 8'(p), 16'(b)}, b == 1, 1'b1);
    for (int b = 0; b < 2; b++) begin
      add_beat(1, {8'h11, 8'hBB, 16'(b)}, b == 1, 1'b0);
      add_beat(0, {8'h00, 8'hCC, 16'(b)}, b == 1, 1'b0);
      add_beat(2, {8'h22, 8'hDD, 16'(b)}, b == 1, 1'b0);
    end
    drive_inputs();
    run(1, 50, to);
    cfg_enable = 4'b1000;
    run(8, 200, to);
    repeat (20) step();
    total++;
    if (obs_q.size() != 8) begin
      bad++;
      $display("FAIL mask_count: got %0d beats want 8", obs_q.size());
    end
    for (int k = 0; k < 8 && k < obs_q.size(); k++) if (obs_q[k] !== exp_q[k]) mism++;
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL mask_order: got %0d mismatched beats want 0", mism);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL mask_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_random();
    bit    to;
    int    nbeats = 0;
    int    rerr   = 0;
    int    extra  = 0;
    int    left   = 0;
    int    max_skip = 0;
    int    skip[M];
    beat_t e;
    beat_t b;
    do_reset();
    ready_mode = 2;
    gap_mode   = 1;
    for (int p = 0; p < 500; p++) begin
      int t   = $urandom_range(0, M - 1);
      int len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        add_beat(t, {8'(t), 12'(p), 12'(k)}, k == len - 1, 1'b0);
        e.tid  = IDW'(t);
        e.last = (k == len - 1);
        e.data = {8'(t), 12'(p), 12'(k)};
        eq[t].push_back(e);
        nbeats++;
      end
    end
    drive_inputs();
    run(nbeats, 40000, to);
    repeat (10) step();
    total++;
    if (to) begin
      bad++;
      $display("FAIL rand_timeout: got %0d beats want %0d", obs_q.size(), nbeats);
    end
    for (int j = 0; j < M; j++) skip[j] = 0;
    foreach (obs_q[k]) begin
      b = obs_q[k];
      if (eq[b.tid].size() == 0) extra++;
      else begin
        e = eq[b.tid].pop_front();
        if (b !== e) begin
          if (rerr == 0) $display("FAIL rand_beat%0d: got %h want %h", k, b, e);
          rerr++;
        end
        if (b.last) begin
          skip[b.tid] = 0;
          for (int j = 0; j < M; j++)
            if (j != int'(b.tid) && eq[j].size() > 0) begin
              skip[j]++;
              if (skip[j] > max_skip) max_skip = skip[j];
            end
        end
      end
    end
    for (int j = 0; j < M; j++) left += eq[j].size();
    total++;
    if (rerr != 0 || extra != 0 || left != 0) begin
      bad++;
      $display("FAIL rand_scoreboard: got bad=%0d extra=%0d missing=%0d want 0 0 0", rerr, extra, left);
    end
    total++;
    if (max_skip > M - 1) begin
      bad++;
      $display("FAIL rand_fairness: got max skipped=%0d want <=%0d", max_skip, M - 1);
    end
    total++;
    if (stall_err != 0 || ready_err != 0) begin
      bad++;
      $display("FAIL rand_protocol: got stall_err=%0d ready_err=%0d want 0 0", stall_err, ready_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
Round-robin packet arbiter sharing one AXI-stream datapath among M requesters. Grant is packet-atomic: held from first beat until the tlast handshake. A single registered output stage drives the shared stream, which typically feeds the skid_buffer input. out_tid identifies the source of each beat.

Parameters:
n, 4, bytes per beat; data width nb = n*8
M, 4, number of requesters (2..16)

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  synchronous, active-high reset
cfg_enable  in  M  per-requester enable mask; disabled requesters are never newly granted
in_tdata  in  M*nb  requester i data at [i*nb +: nb]
in_tvalid  in  M  per-requester valid
in_tlast  in  M  per-requester end-of-packet
in_tready  out  M  per-requester ready
out_tdata  out  nb  shared stream data
out_tvalid  out  1  shared stream valid
out_tlast  out  1  shared stream end-of-packet
out_tid  out  $clog2(M)  index of the requester owning the current output beat
out_tready  in  1  downstream ready
busy  out  1  high while the state is BUSY

Behaviour:
- Reset: state=IDLE, ptr=M-1 (requester 0 has first priority), grant=0, in_tready=0, out_tvalid=0, out_tdata=0, out_tlast=0, out_tid=0, busy=0. A reset mid-packet discards the packet and any held output beat; no partial-packet recovery.
- stage_ready = !out_tvalid | out_tready. The output register loads on any input handshake. It clears out_tvalid on an output handshake when no new beat is loaded in the same cycle.
- IDLE: in_tready=0 for all requesters. Request vector req = in_tvalid & cfg_enable. Search order ptr+1, ptr+2, ... wrapping modulo M; the first set bit wins. If req!=0: grant<=winner, state<=BUSY. Otherwise stay in IDLE.
- BUSY:
  - in_tready[grant]=stage_ready; all other in_tready=0.
  - On each accepted beat: out_tdata<=in_tdata[grant], out_tlast<=in_tlast[grant], out_tid<=grant, out_tvalid<=1.
  - An accepted beat with in_tlast=1 sets state<=IDLE and ptr<=grant.
- cfg_enable changes take effect only at the next IDLE arbitration. Clearing the enable bit of the granted requester does not truncate its packet.
- Latency: with the arbiter in IDLE and in_tvalid asserted before edge k, grant registers at edge k, the beat is accepted at edge k+1, and out_tvalid is high after edge k+1.
- Throughput: one beat per cycle within a packet while out_tready=1. Exactly one IDLE bubble cycle between packets.
- Backpressure: with out_tready=0 and out_tvalid=1, the output holds data, tlast and tid stable and in_tready[grant]=0. No beat is lost or duplicated.
- Simultaneous output drain and input accept in the same cycle is a full-rate pass; out_tvalid stays 1.
- A requester dropping tvalid mid-packet keeps the grant. The arbiter waits indefinitely, with no timeout.
- Single-beat packets (tlast on the first beat) are legal: BUSY lasts one accepted beat.
- Fairness: after requester g completes a packet, every other continuously requesting enabled requester is served before g is served again.

Decomposition:
- Package axis_arb_pkg: state enum {IDLE, BUSY}, the function clog2-based IDW = $clog2(M) width helper, and the type of the rotating-priority mask.
- Sub-module rr_pick: combinational, inputs req[M] and ptr, outputs winner index and any_req. Double-width rotate/mask implementation, no loops over time. The arbiter FSM, grant/ptr registers and output stage live in axis_rr_arbiter.

Test Plan:
1. Reset mid-packet: req0 streams "0123","4567" with no tlast, then areset pulses for 1 cycle -> all outputs 0 on the following cycle and ptr=M-1. Afterwards req1 alone sends "ABCD"+tlast -> out_tid=1 and out_tdata="ABCD".
2. Single requester: req0 sends "0123","4567","89ab" with tlast on the third beat and out_tready=1 -> out_tvalid first high after edge k+1, beats on consecutive cycles, out_tid=0, out_tlast only on "89ab", busy low one cycle later.
3. Round robin: all four requesters hold 2-beat packets valid at once -> order of out_tid is 0,0,1,1,2,2,3,3. With requesters re-requesting, the next order is 0,0,1,1,...
4. Backpressure: out_tready toggles in a 3-low/2-high pattern during a 5-beat packet from req2 -> exactly 5 output handshakes, data in order, out_tdata stable while stalled, no other in_tready asserted.
5. Mask and mid-packet disable: cfg_enable=4'b1010 with all requesting -> only tid 1 and 3 are served. Clearing bit 1 during req1's packet -> the packet completes fully, and req1 is not granted again.
6. Randomized: 500 packets of 1–8 beats across M=4, random in_tvalid gaps of 0–3 and random out_tready -> per-tid scoreboard queues match, zero errors, and no tid starves more than M-1 packets.
